hwpf_req_sink: RTL and testbench

- Receiving end of the prefetcher request interface.
- Accepts line-prefetch requests over a valid/ready port and buffers them in a small FIFO.
- Drops duplicates against queued and in-flight lines.
- Issues surviving requests to the dcache request port only when the CPU is not using it, and tracks outstanding prefetches by transaction ID until their responses return.

---
 rtl/hwpf_req_sink.sv | 150 +++++++++++++++
 tb/tb_hwpf_req_sink.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hwpf_req_sink.sv
// Prefetch request sink: aligns and dedups line requests, queues them, and issues them to
// the dcache port whenever the CPU leaves it idle, tracking outstanding requests per slot.
module hwpf_req_sink #(
    parameter  int unsigned ADDR_WIDTH   = 40,
    parameter  int unsigned LINE_BYTES   = 64,
    parameter  int unsigned QUEUE_DEPTH  = 4,
    parameter  int unsigned MAX_INFLIGHT = 4,
    localparam int unsigned TW           = $clog2(MAX_INFLIGHT)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  pf_req_valid_i,
    output logic                  pf_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] pf_req_addr_i,
    input  logic                  cpu_busy_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic [TW-1:0]         mem_req_tid_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [TW-1:0]         mem_rsp_tid_i,
    output logic                  dropped_o,
    output logic [TW:0]           inflight_cnt_o
);
    localparam int unsigned OB = $clog2(LINE_BYTES);
    localparam int unsigned QW = $clog2(QUEUE_DEPTH);
    localparam logic [QW:0]             PTR_ONE  = {{QW{1'b0}}, 1'b1};
    localparam logic [MAX_INFLIGHT-1:0] SLOT_ONE = {{(MAX_INFLIGHT-1){1'b0}}, 1'b1};

    function automatic logic [TW:0] popcount(input logic [MAX_INFLIGHT-1:0] v);
        logic [TW:0] n;
        n = '0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            n = n + {{TW{1'b0}}, v[i]};
        end
        return n;
    endfunction

    logic [ADDR_WIDTH-1:0]   r_fifo [QUEUE_DEPTH];
    logic [QW:0]             r_wptr, r_rptr;
    logic [MAX_INFLIGHT-1:0] r_slot_vld;
    logic [ADDR_WIDTH-1:0]   r_slot_addr [MAX_INFLIGHT];
    logic                    r_out_vld;
    logic [ADDR_WIDTH-1:0]   r_out_addr;
    logic [TW-1:0]           r_out_tid;
    logic                    r_dropped;
    logic [TW:0]             r_cnt;

    logic [ADDR_WIDTH-1:0]   w_line, w_head;
    logic [QW:0]             w_count;
    logic [QW-1:0]           w_off;
    logic                    w_empty, w_full, w_push_hs, w_push, w_match;
    logic                    w_slot_free, w_load;
    logic [TW-1:0]           w_free_idx;
    logic [MAX_INFLIGHT-1:0] w_rsp_mask, w_load_mask, w_slot_nxt;

    assign w_line    = {pf_req_addr_i[ADDR_WIDTH-1:OB], {OB{1'b0}}};
    assign w_head    = r_fifo[r_rptr[QW-1:0]];
    assign w_count   = r_wptr - r_rptr;
    assign w_empty   = (w_count == '0);
    assign w_full    = w_count[QW];
    assign w_push_hs = pf_req_valid_i && !w_full;
    assign w_push    = w_push_hs && !w_match && !flush_i;

    assign w_slot_free = ~&r_slot_vld;
    assign w_load      = !w_empty && !cpu_busy_i && w_slot_free && (!r_out_vld || mem_req_ready_i);

    // Duplicate detection against live FIFO entries (head included even if popping), output register and slots.
    always_comb begin
        w_match = 1'b0;
        w_off   = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            w_off   = QW'(i) - r_rptr[QW-1:0];
            w_match = w_match | (({1'b0, w_off} < w_count) && (r_fifo[i] == w_line));
        end
        w_match = w_match | (r_out_vld && (r_out_addr == w_line));
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            w_match = w_match | (r_slot_vld[i] && (r_slot_addr[i] == w_line));
        end
    end

    // Lowest free slot and next occupancy; a slot freed this cycle is never the one reserved.
    always_comb begin
        w_free_idx = '0;
        for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
            w_free_idx = r_slot_vld[i] ? w_free_idx : TW'(i);
        end
        w_rsp_mask  = mem_rsp_valid_i ? (SLOT_ONE << mem_rsp_tid_i) : '0;
        w_load_mask = w_load ? (SLOT_ONE << w_free_idx) : '0;
        w_slot_nxt  = (r_slot_vld & ~w_rsp_mask) | w_load_mask;
    end

    // Pending-request FIFO storage and pointers; flush drops everything queued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr[QW-1:0]] <= w_line;
                r_wptr                 <= r_wptr + PTR_ONE;
            end
            if (w_load) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // In-flight slots, output register and registered status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_slot_vld <= '0;
            r_out_vld  <= 1'b0;
            r_out_addr <= '0;
            r_out_tid  <= '0;
            r_dropped  <= 1'b0;
            r_cnt      <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                r_slot_addr[i] <= '0;
            end
        end else begin
            r_slot_vld <= w_slot_nxt;
            r_cnt      <= popcount(w_slot_nxt);
            r_dropped  <= w_push_hs && w_match && !flush_i;
            if (w_load) begin
                r_slot_addr[w_free_idx] <= w_head;
                r_out_vld               <= 1'b1;
                r_out_addr              <= w_head;
                r_out_tid               <= w_free_idx;
            end else if (r_out_vld && mem_req_ready_i) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign pf_req_ready_o  = !w_full;
    assign mem_req_valid_o = r_out_vld;
    assign mem_req_addr_o  = r_out_addr;
    assign mem_req_tid_o   = r_out_tid;
    assign dropped_o       = r_dropped;
    assign inflight_cnt_o  = r_cnt;

endmodule

// File: tb/tb_hwpf_req_sink.sv
// Directed bench for hwpf_req_sink: a scoreboard queue holds the expected issue order and a
// negedge monitor checks every dcache handshake against it.
module tb_hwpf_req_sink;
    localparam int AW = 40;
    localparam int TW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni, flush_i, pf_req_valid_i, pf_req_ready_o, cpu_busy_i;
    logic [AW-1:0] pf_req_addr_i, mem_req_addr_o;
    logic          mem_req_valid_o, mem_req_ready_i, mem_rsp_valid_i, dropped_o;
    logic [TW-1:0] mem_req_tid_o, mem_rsp_tid_i;
    logic [TW:0]   inflight_cnt_o;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [TW-1:0] tid;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_err = 0;
    logic [AW-1:0] l3 [5];

    hwpf_req_sink dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .pf_req_valid_i(pf_req_valid_i), .pf_req_ready_o(pf_req_ready_o),
        .pf_req_addr_i(pf_req_addr_i), .cpu_busy_i(cpu_busy_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_tid_o(mem_req_tid_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_tid_i(mem_rsp_tid_i),
        .dropped_o(dropped_o), .inflight_cnt_o(inflight_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard monitor: every accepted dcache request must match the queue head.
    always @(negedge clk_i) begin
        if (rst_ni && mem_req_valid_o && mem_req_ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL issue_unexpected: got addr=0x%0h tid=%0d, expected no issue",
                         mem_req_addr_o, mem_req_tid_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_req_addr_o !== mon_e.addr || mem_req_tid_o !== mon_e.tid) begin
                    n_err++;
                    $display("FAIL issue: got addr=0x%0h tid=%0d, expected addr=0x%0h tid=%0d",
                             mem_req_addr_o, mem_req_tid_o, mon_e.addr, mon_e.tid);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push(input logic [AW-1:0] a);
        pf_req_valid_i = 1'b1;
        pf_req_addr_i  = a;
        step();
        pf_req_valid_i = 1'b0;
    endtask

    task automatic rsp(input logic [TW-1:0] t);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_tid_i   = t;
        step();
        mem_rsp_valid_i = 1'b0;
    endtask

    task automatic expect_issue(input logic [AW-1:0] a, input logic [TW-1:0] t);
        exp_t e;
        e.addr = a;
        e.tid  = t;
        exp_q.push_back(e);
    endtask

    initial begin
        l3[0] = 40'h30_00; l3[1] = 40'h30_40; l3[2] = 40'h30_80; l3[3] = 40'h30_C0; l3[4] = 40'h31_00;
        rst_ni = 1'b0; flush_i = 1'b0; pf_req_valid_i = 1'b0; pf_req_addr_i = '0;
        cpu_busy_i = 1'b0; mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_tid_i = '0;
        step(); step();
        chk("rst_ready", pf_req_ready_o, 1);
        chk("rst_valid", mem_req_valid_o, 0);
        chk("rst_addr", mem_req_addr_o, 0);
        chk("rst_tid", mem_req_tid_o, 0);
        chk("rst_dropped", dropped_o, 0);
        chk("rst_cnt", inflight_cnt_o, 0);
        rst_ni = 1'b1;
        step();

        // Basic latency: accept in cycle 0, present in cycle 2.
        expect_issue(40'h10_0000_40, 2'd0);
        push(40'h10_0000_47);
        chk("lat_c1_valid", mem_req_valid_o, 0);
        step();
        chk("lat_c2_valid", mem_req_valid_o, 1);
        chk("lat_c2_addr", mem_req_addr_o, 40'h10_0000_40);
        chk("lat_c2_tid", mem_req_tid_o, 0);
        chk("lat_c2_cnt", inflight_cnt_o, 1);
        step();
        rsp(2'd0);
        chk("lat_rsp_cnt", inflight_cnt_o, 0);

        // Same-line duplicate while the head is being popped.
        expect_issue(40'h20_00, 2'd0);
        push(40'h20_00);
        push(40'h20_10);
        chk("dup_dropped", dropped_o, 1);
        step();
        chk("dup_dropped_end", dropped_o, 0);
        rsp(2'd0);
        chk("dup_rsp_cnt", inflight_cnt_o, 0);

        // Backpressure: fill the FIFO, then drain in order until slots run out.
        mem_req_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push(l3[i]);
        chk("bp_ready_full", pf_req_ready_o, 0);
        chk("bp_cnt", inflight_cnt_o, 1);
        chk("bp_head_addr", mem_req_addr_o, l3[0]);
        for (int i = 0; i < 4; i++) expect_issue(l3[i], TW'(i));
        expect_issue(l3[4], 2'd2);
        mem_req_ready_i = 1'b1;
        step(); step(); step(); step();
        chk("bp_slots_full_valid", mem_req_valid_o, 0);
        chk("bp_slots_full_cnt", inflight_cnt_o, 4);
        chk("bp_ready_again", pf_req_ready_o, 1);
        rsp(2'd2);
        step(); step();
        for (int i = 0; i < 4; i++) rsp(TW'(i));
        chk("bp_drain_cnt", inflight_cnt_o, 0);

        // CPU busy blocks loads but never withdraws a presented request.
        cpu_busy_i = 1'b1; mem_req_ready_i = 1'b0;
        push(40'h40_00);
        push(40'h40_40);
        for (int k = 0; k < 3; k++) begin
            chk("busy_no_valid", mem_req_valid_o, 0);
            step();
        end
        cpu_busy_i = 1'b0;
        step();
        cpu_busy_i = 1'b1;
        expect_issue(40'h40_00, 2'd0);
        expect_issue(40'h40_40, 2'd1);
        for (int k = 0; k < 3; k++) begin
            chk("hold_valid", mem_req_valid_o, 1);
            chk("hold_addr", mem_req_addr_o, 40'h40_00);
            chk("hold_tid", mem_req_tid_o, 0);
            if (k == 2) mem_req_ready_i = 1'b1;
            step();
        end
        chk("busy_blocks_reload", mem_req_valid_o, 0);
        cpu_busy_i = 1'b0;
        step(); step(); step();
        rsp(2'd0);
        rsp(2'd1);
        chk("busy_drain_cnt", inflight_cnt_o, 0);

        // Flush: queued lines vanish, in-flight slots keep retiring.
        expect_issue(40'h50_00, 2'd0);
        expect_issue(40'h50_40, 2'd1);
        push(40'h50_00);
        push(40'h50_40);
        step(); step();
        cpu_busy_i = 1'b1;
        push(40'h50_80);
        push(40'h50_C0);
        flush_i = 1'b1;
        push(40'h50_80);
        flush_i = 1'b0;
        chk("flush_no_drop", dropped_o, 0);
        chk("flush_cnt", inflight_cnt_o, 2);
        chk("flush_ready", pf_req_ready_o, 1);
        cpu_busy_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flush_no_issue", mem_req_valid_o, 0);
        end
        rsp(2'd3);
        chk("rsp_free_slot_ignored", inflight_cnt_o, 2);
        rsp(2'd1);
        chk("flush_rsp1_cnt", inflight_cnt_o, 1);
        rsp(2'd0);
        chk("flush_rsp0_cnt", inflight_cnt_o, 0);

        // Asynchronous reset in the middle of a presented request.
        mem_req_ready_i = 1'b0;
        push(40'h60_00);
        push(40'h60_40);
        chk("pre_rst_valid", mem_req_valid_o, 1);
        #3;
        rst_ni = 1'b0;
        #2;
        chk("arst_valid", mem_req_valid_o, 0);
        chk("arst_addr", mem_req_addr_o, 0);
        chk("arst_tid", mem_req_tid_o, 0);
        chk("arst_cnt", inflight_cnt_o, 0);
        chk("arst_ready", pf_req_ready_o, 1);
        step();
        rst_ni = 1'b1;
        mem_req_ready_i = 1'b1;
        expect_issue(40'h60_00, 2'd0);
        push(40'h60_00);
        chk("post_rst_no_drop", dropped_o, 0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        rsp(2'd0);
        chk("final_cnt", inflight_cnt_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
